// File: rtl/fetch_stage.sv
// Program counter and fetch stage feeding decode from a falling-edge-registered instruction memory.
// Latency: one cycle from address presentation to if_valid; one instruction per cycle while id_ready=1.
// Backpressure: !id_ready with a valid output freezes the PC and output registers and drops imem_rd_en combinationally.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   imem_addr          word address {0, pc_q[IMEM_AW+1:2]}
//   imem_rd_en         memory read enable; low in reset and while decode stalls a valid output
//   imem_instr         memory data, registered by the memory on the falling edge
//   redirect_valid/pc  branch/jump/trap redirect; highest priority, target bits [1:0] ignored
//   if_valid/instr/pc  output register towards decode
//   id_ready           decode accepts the output this cycle
//   fetch_count        number of instructions accepted by decode (wraps at 2^32)
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 10,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic advance;
  logic accept;

  // Low bits of the redirect target are forced to zero, so they are never read.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Fetch may advance when the output register is empty or being consumed.
  // BOOT always has an empty output register; HOLD always has a full one,
  // so only the ready term matters there.
  always_comb begin
    advance = 1'b0;
    case (state_q)
      BOOT:    advance = 1'b1;
      HOLD:    advance = id_ready;
      default: advance = !if_valid_q || id_ready;
    endcase
  end

  assign accept = if_valid_q && id_ready;

  // Read enable is combinational from id_ready so a stall never lets the
  // memory overwrite the word that will be needed once decode resumes.
  // A redirect still reads; that word is simply discarded.
  assign imem_rd_en = !rst && (advance || redirect_valid);
  assign imem_addr  = {{(32-IMEM_AW){1'b0}}, pc_q[IMEM_AW+1:2]};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    fetch_count_d = fetch_count_q;

    // Acceptance is counted even when a redirect flushes in the same cycle.
    if (accept) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end

    if (redirect_valid) begin
      // The word read this cycle belongs to the old path: drop it and
      // restart from the target, leaving a single bubble.
      pc_d       = {redirect_pc[31:2], 2'b00};
      if_valid_d = 1'b0;
      state_d    = RUN;
    end else if (advance) begin
      if_instr_d = imem_instr;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + 32'd4;
      state_d    = RUN;
    end else begin
      // Only reachable with a valid output and decode stalled.
      state_d = HOLD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= NOP_INSTR;
      if_pc_q       <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Program-counter and fetch stage that sits directly upstream of the instruction memory.
- Generates the word address and read enable for the instruction memory, which registers its output on the falling clock edge.
- Captures the returned instruction on the next rising edge and presents it with its PC to decode under a valid/ready handshake.
- Handles stalls from decode and PC redirects from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] must be 0
IMEM_AW, 10, instruction memory word-address width (1024 words)
NOP_INSTR, 32'h0000_0013, value driven on if_instr while reset is asserted

Ports:
clk  input  1  system clock, rising-edge logic; the instruction memory samples on the falling edge
rst  input  1  asynchronous, active-high reset
imem_addr  output  32  word address to the instruction memory: {(32-IMEM_AW)'b0, pc_q[IMEM_AW+1:2]}
imem_rd_en  output  1  instruction memory read enable
imem_instr  input  32  instruction memory data, valid after the falling edge of the cycle in which rd_en was high
redirect_valid  input  1  redirect request: branch taken, jump, or trap
redirect_pc  input  32  redirect target as a byte address; bits [1:0] are ignored
if_valid  output  1  if_instr/if_pc hold a valid instruction
id_ready  input  1  decode accepts the instruction this cycle
if_instr  output  32  fetched instruction
if_pc  output  32  byte address of if_instr
fetch_count  output  32  number of instructions accepted by decode (if_valid && id_ready)

Behaviour:
- Reset (async, rst=1):
  - pc_q=RESET_PC, state=BOOT, if_valid=0, if_instr=NOP_INSTR, if_pc=0, fetch_count=0.
  - imem_rd_en=0 while rst is high.
- States:
  - BOOT: first cycle after reset release. imem_rd_en=1, address=RESET_PC. Next posedge: capture the instruction, if_valid=1, pc_q+=4, go to RUN.
  - RUN: output register empty or being consumed. imem_rd_en=1. Each posedge: capture imem_instr into if_instr, pc_q into if_pc, set if_valid=1, pc_q+=4.
  - HOLD: entered from RUN when if_valid && !id_ready.
    - imem_rd_en=0, so the memory output is held.
    - pc_q and the output registers are frozen.
    - Return to RUN in the cycle id_ready=1: rd_en=1 that cycle; the held instruction is accepted and the next one is captured at the posedge.
- Advance rule: fetch advances (capture plus pc_q+=4) when !if_valid || id_ready. The stall signal is combinational from id_ready: imem_rd_en = !rst && (!if_valid || id_ready || redirect_valid).
- Latency: 1 cycle from address presentation to if_valid. Throughput is 1 instruction per cycle with no bubbles while id_ready=1.
- Redirect (highest priority, overrides stall and BOOT):
  - At the posedge with redirect_valid=1: pc_q={redirect_pc[31:2],2'b00}, if_valid=0, state=RUN.
  - The instruction fetched that cycle is discarded.
  - The first instruction from the target appears with if_valid=1 one cycle later (1-cycle bubble).
- Simultaneous if_valid && id_ready && redirect_valid: the current output counts as accepted (fetch_count increments), then the flush applies.
- pc_q increments modulo 2^32. The memory address wraps modulo 2^IMEM_AW words (4 KiB for the default).
- fetch_count increments on every posedge with if_valid && id_ready, and wraps at 2^32.
- Reset asserted mid-operation: all state returns to reset values immediately; no partial instruction is presented afterward.
- Outputs are stable while if_valid && !id_ready; decode may sample in any cycle.

Test Plan:
- Reset, then release with id_ready=1 and mem[0..3]=A0..A3 -> imem_addr 0,1,2,3 on consecutive cycles; if_valid first high 1 cycle after release; (if_pc, if_instr) = (0,A0), (4,A1), (8,A2), (12,A3); fetch_count=4.
- Hold id_ready=0 for 3 cycles while if_pc=8 -> imem_rd_en=0, if_instr/if_pc held at (8,A2); on release the sequence resumes (8,A2), (12,A3) with no skip or duplicate.
- Pulse redirect_valid with redirect_pc=32'h0000_0103 while streaming -> next cycle if_valid=0; then if_pc=32'h100 with mem[64]; fetch_count unchanged unless id_ready was high that cycle.
- Redirect while id_ready=0 -> the stalled instruction is dropped; target fetched regardless of stall; if_valid low for exactly 1 cycle.
- Redirect to 32'h0000_0FFC, run 2 instructions -> imem_addr 1023 then 0; if_pc 32'hFFC then 32'h1000.
- Assert rst mid-stream with if_valid=1 -> if_valid=0, if_instr=32'h13, and fetch_count=0 immediately without waiting for a clock; after release, fetch restarts at RESET_PC.
